// File: rtl/aibnd_dll_lock_ctrl_if.sv
// aibnd_dll_lock_ctrl_if: control, phase-detector and delay-code bundle.
// lock_err exists only when AIBND_DLL_LOCK_TIMEOUT_EN is defined.
interface aibnd_dll_lock_ctrl_if #(
   parameter int CODE_W = 10
);
   logic              en;
   logic              reinit;
   logic              rb_bin_search;
   logic              rb_cont_cal;
   logic              rb_selflock;
   logic [CODE_W-1:0] csr_init_code;
   logic              t_up;
   logic              t_down;
   logic              dll_phdet_reset_n;
   logic              launch;
   logic              measure;
   logic [CODE_W-1:0] dly_code;
   logic [CODE_W-1:0] dly_code_gry;
   logic [CODE_W-1:0] half_code_gry;
   logic              dll_lock;
   logic              cal_busy;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
   logic              lock_err;
`endif

   modport master (
      output en, reinit, rb_bin_search,
      output rb_cont_cal, rb_selflock,
      output csr_init_code, t_up, t_down,
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
      input  lock_err,
`endif
      input  dll_phdet_reset_n, launch, measure,
      input  dly_code, dly_code_gry, half_code_gry,
      input  dll_lock, cal_busy
   );

   modport slave (
      input  en, reinit, rb_bin_search,
      input  rb_cont_cal, rb_selflock,
      input  csr_init_code, t_up, t_down,
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
      output lock_err,
`endif
      output dll_phdet_reset_n, launch, measure,
      output dly_code, dly_code_gry, half_code_gry,
      output dll_lock, cal_busy
   );
endinterface

// File: rtl/aibnd_dll_lock_ctrl.sv
// aibnd_dll_lock_ctrl: DLL delay-code lock controller, binary/linear search.
// Define AIBND_DLL_LOCK_TIMEOUT_EN for the update timeout and lock_err.
module aibnd_dll_lock_ctrl #(
   parameter int CODE_W     = 10,
   parameter int SETTLE_CYC = 8,
   parameter int LOCK_CNT   = 4
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
   ,
   parameter int TIMEOUT_ITER = 64
`endif
) (
   input logic                  clk_pll,
   input logic                  rst,
   aibnd_dll_lock_ctrl_if.slave dll
);
   typedef enum logic [2:0] {
      IDLE, PD_RST, LAUNCH, SETTLE,
      MEASURE, UPDATE, LOCKED, ERR
   } state_t;

   localparam int SW = (SETTLE_CYC > 1) ?
                       $clog2(SETTLE_CYC) : 1;
   localparam int RW = $clog2(LOCK_CNT + 1);
   localparam logic [CODE_W-1:0] MID =
      CODE_W'(1) << (CODE_W - 1);
   localparam logic [CODE_W-1:0] QTR =
      CODE_W'(1) << (CODE_W - 2);
   localparam logic [CODE_W-1:0] MAXC = {CODE_W{1'b1}};

   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [CODE_W-1:0] step_q, step_d;
   logic [SW-1:0]     scnt_q, scnt_d;
   logic [RW-1:0]     rev_q, rev_d;
   logic              pdir_q, pdir_d;
   logic              pvld_q, pvld_d;
   logic              trk_q, trk_d;
   logic              up_q, up_d;
   logic              dn_q, dn_d;
   logic              lock_q, lock_d;
   logic              cc_q;
   logic [CODE_W-1:0] gry_q, hgry_q;
   logic              launch_q, meas_q;
   logic              phn_q, busy_q;

   logic              start, bin, moved;
   logic              up_only, dn_only;
   logic [CODE_W-1:0] stp, nc, hb;
   logic [CODE_W-1:0] gry_d, hgry_d;
   logic [CODE_W:0]   sum, dif;

`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
   localparam int UW = $clog2(TIMEOUT_ITER + 1);
   logic [UW-1:0] upd_q, upd_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      step_d  = step_q;
      scnt_d  = scnt_q;
      rev_d   = rev_q;
      pdir_d  = pdir_q;
      pvld_d  = pvld_q;
      trk_d   = trk_q;
      up_d    = up_q;
      dn_d    = dn_q;
      lock_d  = lock_q;
      start   = 1'b0;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
      upd_d   = upd_q;
      err_d   = err_q;
`endif
      bin     = dll.rb_bin_search && !trk_q;
      up_only = up_q && !dn_q;
      dn_only = dn_q && !up_q;
      stp     = bin ? step_q : CODE_W'(1);
      sum     = {1'b0, code_q} + {1'b0, stp};
      dif     = {1'b0, code_q} - {1'b0, stp};
      nc      = code_q;
      if (up_only)
         nc = sum[CODE_W] ? MAXC : sum[CODE_W-1:0];
      else if (dn_only)
         nc = dif[CODE_W] ? '0 : dif[CODE_W-1:0];
      // a move blocked at either rail counts as a hold
      moved = (nc != code_q);

      if (!dll.en) begin
         state_d = IDLE;
         code_d  = MID;
         step_d  = QTR;
         scnt_d  = '0;
         rev_d   = '0;
         pdir_d  = 1'b0;
         pvld_d  = 1'b0;
         trk_d   = 1'b0;
         up_d    = 1'b0;
         dn_d    = 1'b0;
         lock_d  = 1'b0;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
         upd_d   = '0;
         err_d   = 1'b0;
`endif
      end else if (dll.reinit) begin
         start = 1'b1;
      end else if (dll.rb_selflock) begin
         state_d = LOCKED;
         code_d  = dll.csr_init_code;
         lock_d  = 1'b1;
         trk_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE:    start = 1'b1;
            PD_RST:  state_d = LAUNCH;
            LAUNCH: begin
               state_d = SETTLE;
               scnt_d  = '0;
            end
            SETTLE: begin
               if (scnt_q == SW'(SETTLE_CYC - 1))
                  state_d = MEASURE;
               else
                  scnt_d = scnt_q + 1'b1;
            end
            MEASURE: begin
               up_d    = dll.t_up;
               dn_d    = dll.t_down;
               state_d = UPDATE;
            end
            UPDATE: begin
               code_d = nc;
               if (bin) begin
                  step_d = step_q >> 1;
                  if (step_q == CODE_W'(1))
                     lock_d = 1'b1;
               end else if (moved && !lock_q) begin
                  rev_d = (pvld_q && (pdir_q != up_only)) ?
                          rev_q + 1'b1 : '0;
                  pdir_d = up_only;
                  pvld_d = 1'b1;
                  if (rev_d == RW'(LOCK_CNT))
                     lock_d = 1'b1;
               end
               trk_d   = lock_d && dll.rb_cont_cal;
               state_d = (lock_d && !dll.rb_cont_cal) ?
                         LOCKED : PD_RST;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
               if (!lock_d) begin
                  upd_d = upd_q + 1'b1;
                  if (upd_d == UW'(TIMEOUT_ITER)) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end
               end
`endif
            end
            LOCKED: begin
               if (dll.rb_cont_cal && !cc_q) begin
                  state_d = PD_RST;
                  trk_d   = 1'b1;
               end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
         endcase
      end

      if (start) begin
         state_d = PD_RST;
         code_d  = dll.rb_bin_search ?
                   MID : dll.csr_init_code;
         step_d  = QTR;
         rev_d   = '0;
         pdir_d  = 1'b0;
         pvld_d  = 1'b0;
         trk_d   = 1'b0;
         up_d    = 1'b0;
         dn_d    = 1'b0;
         lock_d  = 1'b0;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
         upd_d   = '0;
         err_d   = 1'b0;
`endif
      end
   end

   assign hb     = code_d >> 1;
   assign gry_d  = code_d ^ (code_d >> 1);
   assign hgry_d = hb ^ (hb >> 1);

   always_ff @(posedge clk_pll or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         code_q   <= MID;
         step_q   <= QTR;
         scnt_q   <= '0;
         rev_q    <= '0;
         pdir_q   <= 1'b0;
         pvld_q   <= 1'b0;
         trk_q    <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         lock_q   <= 1'b0;
         cc_q     <= 1'b0;
         gry_q    <= MID ^ (MID >> 1);
         hgry_q   <= (MID >> 1) ^ (MID >> 2);
         launch_q <= 1'b0;
         meas_q   <= 1'b0;
         phn_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         step_q   <= step_d;
         scnt_q   <= scnt_d;
         rev_q    <= rev_d;
         pdir_q   <= pdir_d;
         pvld_q   <= pvld_d;
         trk_q    <= trk_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         lock_q   <= lock_d;
         cc_q     <= dll.rb_cont_cal;
         gry_q    <= gry_d;
         hgry_q   <= hgry_d;
         launch_q <= (state_d == LAUNCH);
         meas_q   <= (state_d == MEASURE);
         phn_q    <= !(state_d inside {IDLE, PD_RST});
         busy_q   <= !(state_d inside {IDLE, LOCKED, ERR});
      end
   end

`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
   always_ff @(posedge clk_pll or posedge rst) begin
      if (rst) begin
         upd_q <= '0;
         err_q <= 1'b0;
      end else begin
         upd_q <= upd_d;
         err_q <= err_d;
      end
   end

   assign dll.lock_err = err_q;
`endif

   assign dll.dly_code          = code_q;
   assign dll.dly_code_gry      = gry_q;
   assign dll.half_code_gry     = hgry_q;
   assign dll.dll_lock          = lock_q;
   assign dll.launch            = launch_q;
   assign dll.measure           = meas_q;
   assign dll.dll_phdet_reset_n = phn_q;
   assign dll.cal_busy          = busy_q;
endmodule

// File: tb/tb_aibnd_dll_lock_ctrl.sv
// tb_aibnd_dll_lock_ctrl: scoreboard bench for the DLL lock controller.
// Expected codes are queued per test and popped on each code update.
`timescale 1ns/1ps
module tb_aibnd_dll_lock_ctrl;
   localparam int CW = 10;

   typedef struct {
      int code;
      int lock;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tog = 1'b0;
   logic m1 = 1'b0;
   logic m2 = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   lcnt = 0;
   int   pd_mode = 0;
   int   tgt2 = 600;
   int   nstk;
   int   n;
   exp_t sb[$];
   exp_t e;
   int   bc[9] = '{256, 384, 320, 288, 304,
                   296, 300, 300, 300};
   int   lc[9] = '{101, 102, 103, 104, 105,
                   104, 105, 104, 105};

   always #5 clk = ~clk;
   always @(posedge clk) tog <= ~tog;

   aibnd_dll_lock_ctrl_if #(.CODE_W(CW)) ifc();

   aibnd_dll_lock_ctrl #(
      .CODE_W(CW),
      .SETTLE_CYC(8),
      .LOCK_CNT(4)
   ) dut (
      .clk_pll(clk),
      .rst(rst),
      .dll(ifc)
   );

   // phase detector model: compare 2*code with 2*target
   assign ifc.t_up =
      (pd_mode == 0) ? (2 * int'(ifc.dly_code) < tgt2) :
      (pd_mode == 1) ? 1'b1 : tog;
   assign ifc.t_down =
      (pd_mode == 0) ? (2 * int'(ifc.dly_code) > tgt2) : 1'b0;

   task automatic chk(input string nm,
                      input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int c, input int l);
      exp_t x;
      x.code = c;
      x.lock = l;
      sb.push_back(x);
   endtask

   task automatic wait_empty(input string nm, input int lim);
      int k = 0;
      while (sb.size() != 0 && k < lim) begin
         @(posedge clk);
         k++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s: pending %0d want 0", nm, sb.size());
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      if (ifc.launch) lcnt++;
      if (m2) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: got %0d want none",
                     ifc.dly_code);
         end else begin
            e = sb.pop_front();
            chk("upd_code", int'(ifc.dly_code), e.code);
            chk("upd_lock", int'(ifc.dll_lock), e.lock);
         end
      end
      m2 = m1;
      m1 = ifc.measure;
   end

   initial begin
      ifc.en = 0;
      ifc.reinit = 0;
      ifc.rb_bin_search = 0;
      ifc.rb_cont_cal = 0;
      ifc.rb_selflock = 0;
      ifc.csr_init_code = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_code", int'(ifc.dly_code), 'h200);
      chk("rst_gry", int'(ifc.dly_code_gry), 'h300);
      chk("rst_hgry", int'(ifc.half_code_gry), 'h180);
      chk("rst_lock", int'(ifc.dll_lock), 0);
      chk("rst_launch", int'(ifc.launch), 0);
      chk("rst_phn", int'(ifc.dll_phdet_reset_n), 0);
      chk("rst_busy", int'(ifc.cal_busy), 0);
      rst = 0;
      repeat (2) @(posedge clk);
      #1;

      // binary search toward 300
      ifc.rb_bin_search = 1;
      pd_mode = 0;
      tgt2 = 600;
      for (int i = 0; i < 9; i++) push(bc[i], (i == 8) ? 1 : 0);
      ifc.en = 1;
      n = 0;
      while (!ifc.dll_lock && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("bin_lock_cyc", n, 110);
      wait_empty("bin_seq", 50);
      lcnt = 0;
      repeat (30) @(posedge clk);
      #1;
      chk("bin_frozen", int'(ifc.dly_code), 300);
      chk("bin_no_strobe", lcnt, 0);
      chk("bin_busy", int'(ifc.cal_busy), 0);
      ifc.en = 0;
      @(posedge clk);
      #1;
      chk("off_code", int'(ifc.dly_code), 'h200);
      chk("off_lock", int'(ifc.dll_lock), 0);

      // reinit during the third iteration's settle
      push(256, 0);
      push(384, 0);
      ifc.en = 1;
      wait_empty("ri_pre", 60);
      @(posedge clk);
      #1;
      chk("ri_settle_phn", int'(ifc.dll_phdet_reset_n), 1);
      ifc.reinit = 1;
      @(posedge clk);
      #1;
      ifc.reinit = 0;
      chk("ri_code", int'(ifc.dly_code), 'h200);
      chk("ri_lock", int'(ifc.dll_lock), 0);
      chk("ri_phn", int'(ifc.dll_phdet_reset_n), 0);
      for (int i = 0; i < 9; i++) push(bc[i], (i == 8) ? 1 : 0);
      wait_empty("ri_seq", 200);
      ifc.en = 0;
      @(posedge clk);
      #1;

      // linear search toward 104.5
      ifc.rb_bin_search = 0;
      ifc.csr_init_code = 10'd100;
      tgt2 = 209;
      for (int i = 0; i < 9; i++) push(lc[i], (i == 8) ? 1 : 0);
      ifc.en = 1;
      wait_empty("lin_seq", 200);
      pd_mode = 2;
      lcnt = 0;
      repeat (30) @(posedge clk);
      #1;
      chk("lk_code", int'(ifc.dly_code), 105);
      chk("lk_strobe", lcnt, 0);
      chk("lk_lock", int'(ifc.dll_lock), 1);
      pd_mode = 0;
      push(104, 1);
      push(105, 1);
      push(104, 1);
      ifc.rb_cont_cal = 1;
      wait_empty("track_seq", 100);
      #1;
      ifc.en = 0;
      ifc.rb_cont_cal = 0;
      @(posedge clk);
      #1;
      chk("off2_gry", int'(ifc.dly_code_gry), 'h300);
      chk("off2_lock", int'(ifc.dll_lock), 0);

      // linear run into the top rail
      ifc.csr_init_code = 10'd1020;
      pd_mode = 1;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
      nstk = 64;
`else
      nstk = 6;
`endif
      for (int i = 0; i < nstk; i++)
         push((i < 3) ? 1021 + i : 1023, 0);
      ifc.en = 1;
      wait_empty("sat_seq", nstk * 12 + 40);
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
      #1;
      chk("to_err", int'(ifc.lock_err), 1);
      lcnt = 0;
      repeat (30) @(posedge clk);
      #1;
      chk("to_strobe", lcnt, 0);
      chk("to_code", int'(ifc.dly_code), 1023);
`else
      #1;
      chk("sat_code", int'(ifc.dly_code), 1023);
      chk("sat_lock", int'(ifc.dll_lock), 0);
`endif
      ifc.en = 0;
      @(posedge clk);
      #1;
`ifdef AIBND_DLL_LOCK_TIMEOUT_EN
      chk("to_clear", int'(ifc.lock_err), 0);
`endif

      // selflock
      pd_mode = 0;
      ifc.csr_init_code = 10'h155;
      ifc.rb_selflock = 1;
      lcnt = 0;
      ifc.en = 1;
      @(posedge clk);
      #1;
      chk("sl_code", int'(ifc.dly_code), 'h155);
      chk("sl_gry", int'(ifc.dly_code_gry), 'h1FF);
      chk("sl_hgry", int'(ifc.half_code_gry), 'hFF);
      chk("sl_lock", int'(ifc.dll_lock), 1);
      repeat (20) @(posedge clk);
      #1;
      chk("sl_strobe", lcnt, 0);
      chk("sl_busy", int'(ifc.cal_busy), 0);
      ifc.rb_selflock = 0;
      ifc.en = 0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
